// File: rtl/ab_feeder_pkg.sv
// ab_feeder_pkg: shared sizing constants and helpers for the operand feeder.
package ab_feeder_pkg;
   localparam int DEPTH_DEF = 16;
   localparam int OP_W = 8;
   localparam int PAIR_W = 2 * OP_W;
   function automatic int ptr_w(input int depth);
      return $clog2(depth);
   endfunction
endpackage

// File: rtl/ab_fifo.sv
// ab_fifo: synchronous pair FIFO with clear; push when full and pop when empty are ignored.
module ab_fifo
   import ab_feeder_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int PTR_W = ptr_w(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_i,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [PAIR_W-1:0] din_i,
   output logic [PAIR_W-1:0] dout_o,
   output logic              full_o,
   output logic              empty_o,
   output logic [PTR_W:0]    count_o
);
   logic [PAIR_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
   logic [PTR_W:0]    count_q, count_d;
   logic              do_push, do_pop;
   always_comb begin
      do_push = push_i & ~full_o;
      do_pop  = pop_i & ~empty_o;
      wptr_d  = clr_i ? '0 : wptr_q + PTR_W'(do_push);
      rptr_d  = clr_i ? '0 : rptr_q + PTR_W'(do_pop);
      count_d = clr_i ? '0 : count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end
   always_ff @(posedge clk) begin
      if (do_push && !clr_i) mem_q[wptr_q] <= din_i;
   end
   assign dout_o  = mem_q[rptr_q];
   assign full_o  = count_q == (PTR_W+1)'(DEPTH);
   assign empty_o = count_q == '0;
   assign count_o = count_q;
endmodule

// File: rtl/ab_feeder.sv
// ab_feeder: buffers (A,B) operand pairs and hands one per cycle to the MAC stage on REQ_AB.
// The delivery stage is registered: ACK/A/B appear the cycle after the request edge.
module ab_feeder
   import ab_feeder_pkg::*;
#(
   parameter  int DEPTH = DEPTH_DEF,
   localparam int PTR_W = ptr_w(DEPTH)
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            CLR,
   input  logic            WR_EN,
   input  logic [OP_W-1:0] WR_A,
   input  logic [OP_W-1:0] WR_B,
   output logic            FULL,
   output logic            EMPTY,
   output logic [PTR_W:0]  COUNT,
   output logic            OVF,
   input  logic            REQ_AB,
   output logic            ACK,
   output logic [OP_W-1:0] A,
   output logic [OP_W-1:0] B
);
   logic [PAIR_W-1:0] head;
   logic              pop, ack_q, ack_d, ovf_q, ovf_d;
   logic [OP_W-1:0]   a_q, a_d, b_q, b_d;
   assign pop = REQ_AB & ~EMPTY;
   ab_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
      .clk     (CLK),
      .rst     (RST),
      .clr_i   (CLR),
      .push_i  (WR_EN),
      .pop_i   (pop),
      .din_i   ({WR_A, WR_B}),
      .dout_o  (head),
      .full_o  (FULL),
      .empty_o (EMPTY),
      .count_o (COUNT)
   );
   // A dropped write is remembered even if a pop frees a slot on the same edge.
   always_comb begin
      ack_d = ~CLR & pop;
      ovf_d = ~CLR & (ovf_q | (WR_EN & FULL));
      a_d   = ack_d ? head[PAIR_W-1:OP_W] : a_q;
      b_d   = ack_d ? head[OP_W-1:0] : b_q;
   end
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ack_q <= 1'b0;
         ovf_q <= 1'b0;
         a_q   <= '0;
         b_q   <= '0;
      end else begin
         ack_q <= ack_d;
         ovf_q <= ovf_d;
         a_q   <= a_d;
         b_q   <= b_d;
      end
   end
   assign ACK = ack_q;
   assign OVF = ovf_q;
   assign A   = a_q;
   assign B   = b_q;
endmodule

// File: tb/tb_ab_feeder.sv
// tb_ab_feeder: table vectors, directed corner sequences and random traffic against a queue model.
module tb_ab_feeder;
   logic       CLK = 1'b0, RST = 1'b1, CLR = 1'b0, WR_EN = 1'b0, REQ_AB = 1'b0;
   logic [7:0] WR_A = '0, WR_B = '0;
   logic       FULL, EMPTY, OVF, ACK;
   logic [4:0] COUNT;
   logic [7:0] A, B;

   ab_feeder dut (
      .CLK(CLK), .RST(RST), .CLR(CLR), .WR_EN(WR_EN), .WR_A(WR_A), .WR_B(WR_B),
      .FULL(FULL), .EMPTY(EMPTY), .COUNT(COUNT), .OVF(OVF),
      .REQ_AB(REQ_AB), .ACK(ACK), .A(A), .B(B)
   );

   always #5 CLK = ~CLK;

   int checks = 0, failures = 0;
   logic [15:0] mq[$];
   logic        m_ack = 0, m_ovf = 0;
   logic [7:0]  m_a = 0, m_b = 0;

   typedef struct {
      logic wr; logic [7:0] a; logic [7:0] b; logic req; logic clr;
      logic e_ack; logic [7:0] e_a; logic [7:0] e_b; int e_cnt;
   } vec_t;
   vec_t vt[11];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete(); m_ack = 0; m_ovf = 0; m_a = 0; m_b = 0;
   endtask

   // Applies the behavioural rules to the pre-edge inputs and queue occupancy.
   task automatic model_edge(input logic wr, input logic [7:0] a, input logic [7:0] b,
                             input logic req, input logic clr);
      logic full_pre, pop;
      logic [15:0] h;
      if (clr) begin
         mq.delete(); m_ack = 0; m_ovf = 0;
      end else begin
         full_pre = mq.size() == 16;
         pop = req && mq.size() > 0;
         if (pop) begin
            h = mq.pop_front();
            m_a = h[15:8]; m_b = h[7:0];
         end
         m_ack = pop;
         if (wr) begin
            if (full_pre) m_ovf = 1;
            else mq.push_back({a, b});
         end
      end
   endtask

   task automatic chk_all(input string nm);
      chk({nm, ".ACK"}, int'(ACK), int'(m_ack));
      chk({nm, ".A"}, int'(A), int'(m_a));
      chk({nm, ".B"}, int'(B), int'(m_b));
      chk({nm, ".COUNT"}, int'(COUNT), mq.size());
      chk({nm, ".EMPTY"}, int'(EMPTY), int'(mq.size() == 0));
      chk({nm, ".FULL"}, int'(FULL), int'(mq.size() == 16));
      chk({nm, ".OVF"}, int'(OVF), int'(m_ovf));
   endtask

   task automatic step(input logic wr, input logic [7:0] a, input logic [7:0] b,
                       input logic req, input logic clr, input string nm);
      WR_EN = wr; WR_A = a; WR_B = b; REQ_AB = req; CLR = clr;
      @(posedge CLK);
      model_edge(wr, a, b, req, clr);
      #1;
      chk_all(nm);
   endtask

   initial begin
      int nack;
      vt[0]  = '{1, 1, 1, 0, 0, 0, 0, 0, 1};
      vt[1]  = '{1, 2, 2, 0, 0, 0, 0, 0, 2};
      vt[2]  = '{0, 0, 0, 1, 0, 1, 1, 1, 1};
      vt[3]  = '{0, 0, 0, 1, 0, 1, 2, 2, 0};
      vt[4]  = '{0, 0, 0, 1, 0, 0, 2, 2, 0};
      vt[5]  = '{1, 3, 3, 1, 0, 0, 2, 2, 1};
      vt[6]  = '{0, 0, 0, 1, 0, 1, 3, 3, 0};
      vt[7]  = '{1, 4, 4, 0, 0, 0, 3, 3, 1};
      vt[8]  = '{0, 0, 0, 1, 1, 0, 3, 3, 0};
      vt[9]  = '{1, 7, 9, 0, 0, 0, 3, 3, 1};
      vt[10] = '{0, 0, 0, 1, 0, 1, 7, 9, 0};

      // Reset held with writes requested: nothing may be accepted or acknowledged.
      WR_EN = 1; WR_A = 8'h55; WR_B = 8'hAA;
      for (int i = 0; i < 10; i++) begin
         @(posedge CLK); #1;
         chk_all("reset");
      end
      WR_EN = 0; RST = 0;
      step(0, 0, 0, 0, 0, "post_reset");

      for (int i = 0; i < 11; i++) begin
         step(vt[i].wr, vt[i].a, vt[i].b, vt[i].req, vt[i].clr, "vec");
         chk($sformatf("vec%0d.ACK", i), int'(ACK), int'(vt[i].e_ack));
         chk($sformatf("vec%0d.A", i), int'(A), int'(vt[i].e_a));
         chk($sformatf("vec%0d.B", i), int'(B), int'(vt[i].e_b));
         chk($sformatf("vec%0d.COUNT", i), int'(COUNT), vt[i].e_cnt);
      end

      // Fill then stream.
      for (int i = 1; i <= 8; i++) step(1, 1, 8'(i), 0, 0, "fill");
      nack = 0;
      for (int i = 0; i < 9; i++) begin
         step(0, 0, 0, 1, 0, "stream");
         nack += int'(ACK);
         if (i < 8) chk("stream.B", int'(B), i + 1);
         else chk("stream.ack9", int'(ACK), 0);
      end
      chk("stream.nack", nack, 8);
      chk("stream.empty", int'(EMPTY), 1);
      step(0, 0, 0, 0, 0, "idle");

      // Overflow: 17th write dropped, OVF sticky until CLR.
      for (int i = 0; i < 17; i++) begin
         step(1, 8'(i), 8'(i + 100), 0, 0, "ovf_fill");
         if (i == 15) chk("ovf.full16", int'(FULL), 1);
      end
      chk("ovf.flag", int'(OVF), 1);
      chk("ovf.count", int'(COUNT), 16);
      for (int i = 0; i < 16; i++) begin
         step(0, 0, 0, 1, 0, "ovf_drain");
         chk("ovf.drainA", int'(A), i);
      end
      step(0, 0, 0, 1, 0, "ovf_drained");
      chk("ovf.sticky", int'(OVF), 1);
      step(0, 0, 0, 0, 1, "ovf_clr");
      chk("ovf.cleared", int'(OVF), 0);

      // Concurrent push and pop at COUNT=3.
      for (int i = 0; i < 3; i++) step(1, 8'(20 + i), 8'(i), 0, 0, "cc_fill");
      for (int i = 0; i < 5; i++) begin
         step(1, 8'(30 + i), 8'(i), 1, 0, "cc_both");
         chk("cc.count", int'(COUNT), 3);
         chk("cc.ack", int'(ACK), 1);
      end
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, "cc_drain");

      // Wrap-around with interleaved traffic.
      for (int i = 0; i < 40; i++) step(1, 8'($urandom), 8'($urandom), 1'(i % 3 != 0), 0, "wrap");
      for (int i = 0; i < 18; i++) step(0, 0, 0, 1, 0, "wrap_drain");

      // CLR in the middle of a stream.
      for (int i = 0; i < 5; i++) step(1, 8'(50 + i), 8'(60 + i), 0, 0, "clr_fill");
      step(0, 0, 0, 1, 0, "clr_req");
      step(0, 0, 0, 1, 1, "clr_pulse");
      chk("clr.ack", int'(ACK), 0);
      chk("clr.count", int'(COUNT), 0);
      chk("clr.A_hold", int'(A), 50);
      step(1, 7, 9, 0, 0, "clr_push");
      step(0, 0, 0, 1, 0, "clr_deliver");
      chk("clr.next_ack", int'(ACK), 1);
      chk("clr.next_A", int'(A), 7);
      chk("clr.next_B", int'(B), 9);

      // Random traffic.
      for (int i = 0; i < 2000; i++)
         step(1'($urandom_range(0, 2) != 0), 8'($urandom), 8'($urandom),
              1'($urandom_range(0, 2) == 0 || i > 1800), 1'($urandom_range(0, 99) == 0), "rand");

      // Asynchronous reset mid-stream.
      for (int i = 0; i < 5; i++) step(1, 8'(i + 1), 8'(i + 2), 0, 0, "ar_fill");
      step(0, 0, 0, 1, 0, "ar_req");
      REQ_AB = 1;
      #3 RST = 1;
      #1;
      model_reset();
      chk_all("async_reset");
      @(posedge CLK); #1;
      chk_all("async_reset_hold");
      RST = 0;
      step(0, 0, 0, 1, 0, "after_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
